// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - glyph constants and scan FSM state type
// Glyphs are active-low {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seven_segment_scan_if.sv
// rtl/seven_segment_scan_if.sv - display request/pin bundle for seven_segment_scan
// master: value producer (drives enable, value, dp_in; sees the pins)
// slave : scan driver    (reads the request; drives seg, dp, an, frame_start)
interface seven_segment_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_start;

  modport master (
    output enable, value, dp_in,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  enable, value, dp_in,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational nibble to active-low glyph
// i_nibble : 4-bit value to display
// o_seg    : {g,f,e,d,c,b,a}, active-low
// HEX_MODE : 1 shows A-F glyphs, 0 shows a dash for 10-15
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = (HEX_MODE != 0) ? SEG_A : SEG_DASH;
      4'hB: o_seg = (HEX_MODE != 0) ? SEG_B : SEG_DASH;
      4'hC: o_seg = (HEX_MODE != 0) ? SEG_C : SEG_DASH;
      4'hD: o_seg = (HEX_MODE != 0) ? SEG_D : SEG_DASH;
      4'hE: o_seg = (HEX_MODE != 0) ? SEG_E : SEG_DASH;
      4'hF: o_seg = (HEX_MODE != 0) ? SEG_F : SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed common-anode seven-segment scanner
// clk, rst_n : clock and async active-low reset
// bus.enable : 0 forces the display dark
// bus.value  : packed nibbles, value[3:0] is digit 0 (an[0], rightmost)
// bus.dp_in  : per-digit decimal point request, 1 = lit
// bus.seg/dp/an : active-low registered pins
// bus.frame_start : one-cycle pulse when the frame buffer loads
// Optional: `define SEVEN_SEGMENT_LZ_BLANK_EN blanks leading zero digits.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int HEX_MODE     = 1
) (
  input logic                clk,
  input logic                rst_n,
  seven_segment_scan_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  // With no blanking interval a slot opens straight into SHOW.
  localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  scan_state_t          r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [4*DIGITS-1:0]  r_vbuf;
  logic [DIGITS-1:0]    r_dpbuf;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame_start;

  scan_state_t          w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_load;
  logic [4*DIGITS-1:0]  w_vbuf_nxt;
  logic [DIGITS-1:0]    w_dpbuf_nxt;
  logic [3:0]           w_nibble;
  logic                 w_dp_sel;
  logic [DIGITS-1:0]    w_an_sel;
  logic [6:0]           w_glyph;
  logic [6:0]           w_seg_show;

  // Next-state logic. w_load marks a slot start for digit 0, i.e. a frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_OFF;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = SLOT_ENTRY;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        ST_SHOW: begin
          if (r_cnt == SLOT_LAST) begin
            w_state_nxt = SLOT_ENTRY;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt = '0;
              w_load    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered on the edge that enters a state, so the glyph is
  // built from the buffer contents and digit index that will be in effect
  // after this edge (including a buffer reload on the same edge).
  assign w_vbuf_nxt  = w_load ? bus.value : r_vbuf;
  assign w_dpbuf_nxt = w_load ? bus.dp_in : r_dpbuf;

  always_comb begin
    w_nibble = 4'h0;
    w_dp_sel = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nibble    = w_vbuf_nxt[4*i +: 4];
        w_dp_sel    = w_dpbuf_nxt[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  seven_segment_decoder #(
    .HEX_MODE (HEX_MODE)
  ) u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
  logic [DIGITS-1:0] w_lead_zero;
  logic              w_zero_from_top;

  // Walk down from the top digit; a digit is a leading zero while every
  // nibble from it upward is zero. Digit 0 is never blanked.
  always_comb begin
    w_lead_zero     = '0;
    w_zero_from_top = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_from_top = w_zero_from_top & (w_vbuf_nxt[4*i +: 4] == 4'h0);
      w_lead_zero[i]  = w_zero_from_top & (i != 0);
    end
  end

  assign w_seg_show = (|(w_lead_zero & ~w_an_sel)) ? SEG_BLANK : w_glyph;
`else
  assign w_seg_show = w_glyph;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_OFF;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_vbuf        <= '0;
      r_dpbuf       <= '0;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_vbuf        <= w_vbuf_nxt;
      r_dpbuf       <= w_dpbuf_nxt;
      r_frame_start <= w_load;
      if (w_state_nxt == ST_SHOW) begin
        r_an  <= w_an_sel;
        r_seg <= w_seg_show;
        r_dp  <= ~w_dp_sel;
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.an          = r_an;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;

  int checks;
  int passed;

  seven_segment_scan_if #(.DIGITS(4)) if_hex ();
  seven_segment_scan_if #(.DIGITS(4)) if_dash ();

  assign if_hex.enable  = enable;
  assign if_hex.value   = value;
  assign if_hex.dp_in   = dp_in;
  assign if_dash.enable = enable;
  assign if_dash.value  = value;
  assign if_dash.dp_in  = dp_in;

  seven_segment_scan #(
    .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_hex)
  );

  seven_segment_scan #(
    .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(0)
  ) dut_dash (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_dash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Force OFF for one edge, then present the request so that the next
  // rising edge (edge k) opens the digit-0 blank slot.
  task automatic start_frame(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    value  = v;
    dp_in  = d;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    value  = 16'h0;
    dp_in  = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_outputs got an=%b seg=%h dp=%b fs=%b exp an=1111 seg=7f dp=1 fs=0",
               if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_hex.an, if_hex.seg, if_hex.frame_start} !== {4'hF, 7'h7F, 1'b0})
      $display("FAIL idle_disabled got an=%b seg=%h fs=%b exp an=1111 seg=7f fs=0",
               if_hex.an, if_hex.seg, if_hex.frame_start);
    else passed++;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    start_frame(16'h1234, 4'b0000);
    for (int c = 0; c < 64; c++) begin
      int         slot;
      int         pos;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      @(negedge clk);
      slot  = (c / 8) % 4;
      pos   = c % 8;
      an_e  = (pos < 2) ? 4'hF : ~(4'b0001 << slot);
      seg_e = (pos < 2) ? 7'h7F : exp_seg[slot];
      checks++;
      if (if_hex.an !== an_e)
        $display("FAIL scan_an c=%0d got %b exp %b", c, if_hex.an, an_e);
      else passed++;
      checks++;
      if (if_hex.seg !== seg_e)
        $display("FAIL scan_seg c=%0d got %h exp %h", c, if_hex.seg, seg_e);
      else passed++;
      checks++;
      if (if_hex.dp !== 1'b1)
        $display("FAIL scan_dp c=%0d got %b exp 1", c, if_hex.dp);
      else passed++;
      checks++;
      if (if_hex.frame_start !== (c % 32 == 0))
        $display("FAIL scan_frame_start c=%0d got %b exp %b", c, if_hex.frame_start, (c % 32 == 0));
      else passed++;
    end
  endtask

  task automatic test_frame_buffer();
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    old_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    new_seg = '{7'h00, 7'h78, 7'h02, 7'h12};
    start_frame(16'h1234, 4'b0000);
    for (int c = 0; c < 64; c++) begin
      int         slot;
      int         pos;
      logic [6:0] seg_e;
      @(negedge clk);
      slot  = (c / 8) % 4;
      pos   = c % 8;
      seg_e = (pos < 2) ? 7'h7F : ((c < 32) ? old_seg[slot] : new_seg[slot]);
      checks++;
      if (if_hex.seg !== seg_e)
        $display("FAIL frame_buffer_seg c=%0d got %h exp %h", c, if_hex.seg, seg_e);
      else passed++;
      checks++;
      if (if_hex.frame_start !== (c % 32 == 0))
        $display("FAIL frame_buffer_fs c=%0d got %b exp %b", c, if_hex.frame_start, (c % 32 == 0));
      else passed++;
      if (c == 12) value = 16'h5678;
    end
  endtask

  task automatic test_hex_mode();
    logic [6:0] hex_seg [4];
    logic [6:0] dash_seg [4];
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
    hex_seg  = '{7'h0E, 7'h08, 7'h7F, 7'h7F};
    dash_seg = '{7'h3F, 7'h3F, 7'h7F, 7'h7F};
`else
    hex_seg  = '{7'h0E, 7'h08, 7'h40, 7'h40};
    dash_seg = '{7'h3F, 7'h3F, 7'h40, 7'h40};
`endif
    start_frame(16'h00AF, 4'b0000);
    for (int c = 0; c < 32; c++) begin
      int slot;
      int pos;
      @(negedge clk);
      slot = c / 8;
      pos  = c % 8;
      if (pos >= 2) begin
        checks++;
        if (if_hex.seg !== hex_seg[slot])
          $display("FAIL hex_mode1_seg c=%0d got %h exp %h", c, if_hex.seg, hex_seg[slot]);
        else passed++;
        checks++;
        if (if_dash.seg !== dash_seg[slot])
          $display("FAIL hex_mode0_seg c=%0d got %h exp %h", c, if_dash.seg, dash_seg[slot]);
        else passed++;
      end
    end
  endtask

  task automatic test_enable_drop();
    start_frame(16'h1234, 4'b0000);
    repeat (21) @(negedge clk);
    checks++;
    if ({if_hex.an, if_hex.seg} !== {4'b1011, 7'h24})
      $display("FAIL drop_pre_digit2 got an=%b seg=%h exp an=1011 seg=24", if_hex.an, if_hex.seg);
    else passed++;
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
        $display("FAIL drop_dark c=%0d got an=%b seg=%h dp=%b fs=%b exp an=1111 seg=7f dp=1 fs=0",
                 c, if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start);
      else passed++;
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_hex.an, if_hex.frame_start} !== {4'hF, 1'b1})
      $display("FAIL reenable_start got an=%b fs=%b exp an=1111 fs=1", if_hex.an, if_hex.frame_start);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_hex.an, if_hex.seg, if_hex.frame_start} !== {4'b1110, 7'h19, 1'b0})
      $display("FAIL reenable_digit0 got an=%b seg=%h fs=%b exp an=1110 seg=19 fs=0",
               if_hex.an, if_hex.seg, if_hex.frame_start);
    else passed++;
  endtask

  task automatic test_dp();
    start_frame(16'h1234, 4'b0100);
    for (int c = 0; c < 32; c++) begin
      int   slot;
      int   pos;
      logic dp_e;
      @(negedge clk);
      slot = c / 8;
      pos  = c % 8;
      dp_e = (slot == 2 && pos >= 2) ? 1'b0 : 1'b1;
      checks++;
      if (if_hex.dp !== dp_e)
        $display("FAIL dp_digit2 c=%0d got %b exp %b (an=%b)", c, if_hex.dp, dp_e, if_hex.an);
      else passed++;
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] seven_seg [4];
    logic [6:0] zero_seg [4];
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
    seven_seg = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
    zero_seg  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    seven_seg = '{7'h78, 7'h40, 7'h40, 7'h40};
    zero_seg  = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    start_frame(16'h0007, 4'b0000);
    for (int c = 0; c < 32; c++) begin
      int         slot;
      int         pos;
      logic [3:0] an_e;
      @(negedge clk);
      slot = c / 8;
      pos  = c % 8;
      an_e = (pos < 2) ? 4'hF : ~(4'b0001 << slot);
      if (pos >= 2) begin
        checks++;
        if ({if_hex.an, if_hex.seg} !== {an_e, seven_seg[slot]})
          $display("FAIL lz_0007 c=%0d got an=%b seg=%h exp an=%b seg=%h",
                   c, if_hex.an, if_hex.seg, an_e, seven_seg[slot]);
        else passed++;
      end
    end
    start_frame(16'h0000, 4'b0000);
    for (int c = 0; c < 32; c++) begin
      int slot;
      int pos;
      @(negedge clk);
      slot = c / 8;
      pos  = c % 8;
      if (pos >= 2) begin
        checks++;
        if (if_hex.seg !== zero_seg[slot])
          $display("FAIL lz_0000 c=%0d got %h exp %h", c, if_hex.seg, zero_seg[slot]);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    start_frame(16'h1234, 4'b1111);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL async_reset got an=%b seg=%h dp=%b fs=%b exp an=1111 seg=7f dp=1 fs=0",
               if_hex.an, if_hex.seg, if_hex.dp, if_hex.frame_start);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_scan();
    test_frame_buffer();
    test_hex_mode();
    test_enable_drop();
    test_dp();
    test_lz_blank();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed seven-segment display driver that scans `DIGITS` common-anode digits from one packed nibble vector. It is the clocked successor to the combinational switch-to-segment decoder. It sits between the value-producing logic and the board's `seg`/`an`/`dp` pins. Additions over the decoder:
- frame-buffered input capture, so there is no tearing mid-scan;
- a ghost-suppression blanking interval between digits;
- an enable/off mode.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; 1..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot, blank plus show; must be at least 2.
- `BLANK_CYCLES`, 1000: all-off cycles at the start of each slot; 0..`REFRESH_DIV`-1; 0 removes the BLANK state.
- `HEX_MODE`, 1: 1 shows nibbles A–F as hex glyphs; 0 shows nibbles 10–15 as a dash (segment g only).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `enable`, in, 1: scan enable; 0 turns the display dark.
- `value`, in, 4*`DIGITS`: packed nibbles; `value[3:0]` drives digit 0, the rightmost, on `an[0]`.
- `dp_in`, in, `DIGITS`: decimal point request per digit, 1 = lit.
- `seg`, out, 7: `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp`, out, 1: decimal point, active-low, registered.
- `an`, out, `DIGITS`: anode selects, active-low, one-cold or all-high, registered.
- `frame_start`, out, 1: one-cycle pulse when the frame buffer loads.

## Operation
- FSM states: OFF, BLANK, SHOW. Datapath registers:
  - digit index `idx`, range 0..`DIGITS`-1;
  - slot counter `cnt`, width `$clog2(REFRESH_DIV)`;
  - frame buffers `vbuf` and `dpbuf`.
- Reset values: state OFF, `idx`=0, `cnt`=0, `vbuf`=0, `dpbuf`=0, `seg`=7'h7F, `dp`=1, `an`=all ones, `frame_start`=0.
- OFF to slot start: when `enable`=1, the FSM enters BLANK with `idx`=0, or SHOW with `idx`=0 if `BLANK_CYCLES`=0.
- Slot start for digit 0 does three things: loads `vbuf`←`value` and `dpbuf`←`dp_in`, and pulses `frame_start`.
- BLANK: `an` all ones, `seg`=7'h7F, `dp`=1. Lasts exactly `BLANK_CYCLES` cycles, then goes to SHOW.
- SHOW:
  - `an[idx]`=0 and all other anode bits are 1.
  - `seg`=decode(`vbuf[4*idx+:4]`).
  - `dp`=~`dpbuf[idx]`.
  - Lasts `REFRESH_DIV`-`BLANK_CYCLES` cycles.
- End of SHOW: `idx` increments. At `DIGITS`-1 it wraps to 0, and the wrap is a frame boundary (buffer reload plus `frame_start`). Then the next slot starts.
- Any state, `enable`=0 sampled: next edge goes to OFF with dark outputs. `idx` and `cnt` clear. `vbuf` holds its contents.
- Changes to `value` between frame boundaries have no visible effect until the next boundary.
- Decode for 0–9 uses the standard glyphs. 10–15 follow `HEX_MODE`.
- `DIGITS`=1: every slot is a frame boundary.
- Reset asserted mid-frame: outputs go to their reset values asynchronously.

## Timing
- Outputs are registered. `seg`, `an`, `dp` and `frame_start` change on the same edge that the FSM enters a state. There is no extra pipeline stage.
- Frame period is `DIGITS`×`REFRESH_DIV` cycles.
- `enable` rises at edge k (first edge where it is sampled 1):
  - BLANK for digit 0 starts at edge k and `frame_start`=1 in cycle k;
  - `an[0]`=0 from edge k+`BLANK_CYCLES`;
  - digit 1 slot starts at edge k+`REFRESH_DIV`.
- `enable` falls, sampled at edge j: outputs are dark from edge j.
- At most one anode is ever low. No two anodes are ever low on the same cycle, including at transitions.

## Configuration
- Macro `SEVEN_SEGMENT_LZ_BLANK_EN`.
- Defined: leading-zero blanking, evaluated on `vbuf`.
  - Digits above the most significant nonzero nibble show `seg`=7'h7F.
  - Digit 0 always displays.
  - `an` scanning and `dp` are unaffected.
- Undefined: every digit is decoded, and no blanking logic is present.

## Structure
- `seven_segment_pkg` holds:
  - glyph constants `SEG_0`..`SEG_F`, `SEG_BLANK` (7'h7F) and `SEG_DASH` (7'h3F);
  - the FSM state enum typedef.
- One sub-module, `seven_segment_decoder`:
  - combinational nibble-to-glyph conversion with `HEX_MODE` as a parameter;
  - instantiated once on the muxed nibble.

## Test plan
All scenarios use `DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset then `enable`=1, `value`=16'h1234, `dp_in`=0: per 32-cycle frame the bench sees
  - `an` in the order 1110, 1101, 1011, 0111, each low for 6 cycles after 2 all-high cycles;
  - `seg` in the order 7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1);
  - `frame_start` once every 32 cycles.
- `value` changes from 16'h1234 to 16'h5678 mid-frame: the current frame completes showing 1234, and 5678 appears only after the next `frame_start`.
- `HEX_MODE`=0 with `value`=16'h00AF: digits 0 and 1 show 7'h3F. `HEX_MODE`=1 with the same value shows 7'h0E (F) and 7'h08 (A).
- `enable` dropped during SHOW of digit 2: dark outputs on the next edge. Re-enable restarts at digit 0 with a fresh `frame_start`.
- `dp_in`=4'b0100: `dp`=0 only while `an`=1011, otherwise 1.
- `SEVEN_SEGMENT_LZ_BLANK_EN` defined with `value`=16'h0007: digits 3, 2 and 1 show 7'h7F while their anodes still scan, and digit 0 shows 7'h78. `value`=0 shows a single 7'h40 (0) on digit 0.
